sysid_boot_checker: RTL
=======================

// Module: sysid_boot_checker
// PURPOSE
//  Avalon-MM read master that sequences the system-ID slave (addr 0 = ID, addr 1 = build timestamp).
//  After reset or on request it reads ID then timestamp, compares both to expected values and
//  reports pass/fail, so the game logic refuses to run against a mismatched/stale FPGA image.
//  Sits between top-level reset/control and the sysid control_slave; the only master on that port.
// PARAMETERS
//  EXPECTED_ID        32'h0000_0000   value required at address 0
//  EXPECTED_TS        32'd1480905656  value required at address 1
//  TIMEOUT_CYCLES     255             max cycles per access (request+data) before abort; 1..65535
//  MAX_RETRIES        3               full-sequence retries after a timeout; 0..15
//  USE_READDATAVALID  0               0: data captured in accept cycle; 1: captured on avm_readdatavalid
//  AUTO_START         1               1: run one check automatically after reset deasserts
// PORTS
//  clock              in   1   system clock
//  reset              in   1   synchronous, active-high
//  start              in   1   pulse: begin check (ignored while busy)
//  avm_address        out  1   0 = ID, 1 = timestamp
//  avm_read           out  1   read request, held until accepted
//  avm_waitrequest    in   1   slave stall; tie 0 for zero-wait slave
//  avm_readdata       in   32  read data
//  avm_readdatavalid  in   1   used only when USE_READDATAVALID=1
//  busy               out  1   sequence in progress
//  done               out  1   level: result valid, held until next start
//  pass               out  1   ID and TS both matched
//  id_mismatch        out  1   ID read but differed from EXPECTED_ID
//  ts_mismatch        out  1   TS read but differed from EXPECTED_TS
//  timeout            out  1   retries exhausted without completing
//  id_value           out  32  last captured ID
//  ts_value           out  32  last captured TS
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, retry count 0, timer 0. Reset mid-sequence aborts immediately
//    (avm_read low next edge); no result reported.
//  - States: IDLE -> RD_ID -> [WT_ID] -> RD_TS -> [WT_TS] -> CHECK -> DONE. DONE -> RD_ID on start.
//    WT_* entered only when USE_READDATAVALID=1.
//  - RD_x: avm_read=1, avm_address fixed; accepted on a cycle with avm_read=1 & avm_waitrequest=0.
//    USE_READDATAVALID=0: capture readdata that cycle, advance. =1: drop avm_read next cycle,
//    wait in WT_x for readdatavalid, capture, advance. readdatavalid outside WT_x is ignored.
//  - Address/read never change while avm_waitrequest=1 (Avalon hold rule).
//  - Timer: clears on entering RD_x; counts each cycle in RD_x/WT_x; on reaching TIMEOUT_CYCLES
//    abort: avm_read=0, retry_cnt++, restart at RD_ID (captured values kept). If retry_cnt already
//    == MAX_RETRIES -> DONE with timeout=1, pass=0.
//  - CHECK: compare registered values (full 32-bit equality); pass = both equal; mismatch flags set
//    independently. Next cycle DONE: done=1, busy=0.
//  - Latency (zero-wait, USE_READDATAVALID=0): start sampled at cycle N -> avm_read cycles N+1
//    (addr 0), N+2 (addr 1); CHECK N+3; done=1 from N+4.
//  - start in IDLE or DONE: clear done/pass/flags/retry_cnt, busy=1 next cycle. start while busy:
//    ignored, no queueing. start coincident with reset: reset wins.
//  - AUTO_START=1: first cycle with reset low acts as start; AUTO_START=0 waits in IDLE.
// STRUCTURE
//  - sysid_ctrl_pkg: state enum (IDLE, RD_ID, WT_ID, RD_TS, WT_TS, CHECK, DONE), ADDR_ID=1'b0,
//    ADDR_TS=1'b1 constants.
//  - One sub-module: sysid_ctrl_timer (load/enable/expire counter, width $clog2(TIMEOUT_CYCLES+1)).
//  - FSM, capture registers and compare in top module; all outputs registered.
// TESTING
//  1. Zero-wait model returning 0 / 1480905656, start at cycle 10 -> done=1,pass=1 at cycle 14,
//     exactly two read cycles, addresses 0 then 1.
//  2. Model returns TS=32'h12345678 -> done=1, pass=0, ts_mismatch=1, id_mismatch=0, ts_value=12345678.
//  3. waitrequest high 5 cycles on each access -> avm_read/address stable throughout, pass=1
//     at start+14.
//  4. waitrequest stuck high, TIMEOUT_CYCLES=8, MAX_RETRIES=2 -> three 8-cycle attempts, then
//     timeout=1, pass=0, done=1.
//  5. USE_READDATAVALID=1, readdatavalid 3 cycles after accept; spurious valid in IDLE -> ignored,
//     pass=1.
//  6. reset asserted during WT_TS, start pulsed while busy -> outputs 0 after reset edge; busy
//     start has no effect on sequence count.

Source files
------------

// File: rtl/sysid_ctrl_pkg.sv
// Shared constants for the system-ID boot checker: FSM state encodings and
// the two sysid slave register addresses.
package sysid_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t RD_ID = 3'd1;
  localparam state_t WT_ID = 3'd2;
  localparam state_t RD_TS = 3'd3;
  localparam state_t WT_TS = 3'd4;
  localparam state_t CHECK = 3'd5;
  localparam state_t DONE  = 3'd6;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_ctrl_timer.sv
// Per-access watchdog: cleared by load, advances while enabled, and flags
// expiry on the enabled cycle that completes TIMEOUT_CYCLES counts.
module sysid_ctrl_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic load_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_q, count_d;

  // Saturates at LAST so expiry stays asserted until the controller reloads.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/sysid_boot_checker.sv
// Avalon-MM read master that fetches the sysid ID and build timestamp,
// compares them against the expected image values and reports the verdict.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID       = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS       = 32'd1480905656,
  parameter int unsigned TIMEOUT_CYCLES    = 255,
  parameter int unsigned MAX_RETRIES       = 3,
  parameter bit          USE_READDATAVALID = 1'b0,
  parameter bit          AUTO_START        = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  import sysid_ctrl_pkg::*;

  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);

  state_t      state_q, state_d;
  logic [3:0]  retry_q, retry_d;
  logic        gap_q, gap_d;
  logic        autoPend_q;
  logic        read_q, read_d;
  logic        addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        idMis_q, idMis_d;
  logic        tsMis_q, tsMis_d;
  logic        timeout_q, timeout_d;
  logic [31:0] idValue_q, idValue_d;
  logic [31:0] tsValue_q, tsValue_d;

  logic timerLoad, timerEn, timerExpire;
  logic startEff, accept, launch, abort;

  assign startEff = start || autoPend_q;
  assign accept   = read_q && !avm_waitrequest;
  assign timerEn  = (((state_q == RD_ID) || (state_q == RD_TS)) && read_q) ||
                    (state_q == WT_ID) || (state_q == WT_TS);

  sysid_ctrl_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load_i  (timerLoad),
    .enable_i(timerEn),
    .expire_o(timerExpire)
  );

  // An abort spends one cycle in RD_ID with read low (gap_q) so the retry
  // never changes address while a stalled request is still being presented.
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    gap_d     = gap_q;
    read_d    = read_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    idMis_d   = idMis_q;
    tsMis_d   = tsMis_q;
    timeout_d = timeout_q;
    idValue_d = idValue_q;
    tsValue_d = tsValue_q;
    timerLoad = 1'b0;
    launch    = 1'b0;
    abort     = 1'b0;

    case (state_q)
      IDLE, DONE: launch = startEff;
      RD_ID: begin
        if (gap_q) begin
          gap_d     = 1'b0;
          read_d    = 1'b1;
          timerLoad = 1'b1;
        end else if (accept) begin
          if (USE_READDATAVALID) begin
            read_d  = 1'b0;
            state_d = WT_ID;
          end else begin
            idValue_d = avm_readdata;
            addr_d    = ADDR_TS;
            timerLoad = 1'b1;
            state_d   = RD_TS;
          end
        end else if (timerExpire) begin
          abort = 1'b1;
        end
      end
      WT_ID: begin
        if (avm_readdatavalid) begin
          idValue_d = avm_readdata;
          read_d    = 1'b1;
          addr_d    = ADDR_TS;
          timerLoad = 1'b1;
          state_d   = RD_TS;
        end else if (timerExpire) begin
          abort = 1'b1;
        end
      end
      RD_TS: begin
        if (accept) begin
          read_d = 1'b0;
          if (USE_READDATAVALID) begin
            state_d = WT_TS;
          end else begin
            tsValue_d = avm_readdata;
            state_d   = CHECK;
          end
        end else if (timerExpire) begin
          abort = 1'b1;
        end
      end
      WT_TS: begin
        if (avm_readdatavalid) begin
          tsValue_d = avm_readdata;
          state_d   = CHECK;
        end else if (timerExpire) begin
          abort = 1'b1;
        end
      end
      CHECK: begin
        idMis_d = (idValue_q != EXPECTED_ID);
        tsMis_d = (tsValue_q != EXPECTED_TS);
        pass_d  = (idValue_q == EXPECTED_ID) && (tsValue_q == EXPECTED_TS);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end
      default: begin
        read_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (launch) begin
      state_d   = RD_ID;
      read_d    = 1'b1;
      addr_d    = ADDR_ID;
      busy_d    = 1'b1;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      idMis_d   = 1'b0;
      tsMis_d   = 1'b0;
      timeout_d = 1'b0;
      retry_d   = '0;
      gap_d     = 1'b0;
      timerLoad = 1'b1;
    end

    if (abort) begin
      read_d    = 1'b0;
      addr_d    = ADDR_ID;
      timerLoad = 1'b1;
      if (retry_q == RETRY_LIMIT) begin
        state_d   = DONE;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        timeout_d = 1'b1;
        pass_d    = 1'b0;
      end else begin
        retry_d = retry_q + 1'b1;
        gap_d   = 1'b1;
        state_d = RD_ID;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      retry_q    <= '0;
      gap_q      <= 1'b0;
      autoPend_q <= AUTO_START;
      read_q     <= 1'b0;
      addr_q     <= ADDR_ID;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      idMis_q    <= 1'b0;
      tsMis_q    <= 1'b0;
      timeout_q  <= 1'b0;
      idValue_q  <= '0;
      tsValue_q  <= '0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      gap_q      <= gap_d;
      autoPend_q <= 1'b0;
      read_q     <= read_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      idMis_q    <= idMis_d;
      tsMis_q    <= tsMis_d;
      timeout_q  <= timeout_d;
      idValue_q  <= idValue_d;
      tsValue_q  <= tsValue_d;
    end
  end

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_mismatch = idMis_q;
  assign ts_mismatch = tsMis_q;
  assign timeout     = timeout_q;
  assign id_value    = idValue_q;
  assign ts_value    = tsValue_q;

endmodule
